// File: rtl/duck_game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : duck_game_pkg
// Brief   : Shared types and geometry for the duck game engine.
// Revision: 1.0 - initial release
// ============================================================================
package duck_game_pkg;

    typedef enum logic [1:0] {
        FLY  = 2'd0,
        FALL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_pos_w = 11;

    // Screen bounds for the duck's top-left corner
    localparam int c_bound_x_min = 10;
    localparam int c_bound_x_max = 1197;
    localparam int c_bound_y_min = 10;
    localparam int c_bound_y_max = 536;

    localparam int c_duck_w    = 71;
    localparam int c_duck_h    = 54;
    localparam int c_aim_off_x = 15;
    localparam int c_aim_off_y = 13;

endpackage
`default_nettype wire

// File: rtl/duck_hit_detect.sv
`default_nettype none
// ============================================================================
// Module  : duck_hit_detect
// Brief   : Combinational test of whether the aim centre lies strictly inside
//           the duck sprite box.
// Revision: 1.0 - initial release
// ============================================================================
module duck_hit_detect
    import duck_game_pkg::*;
(
    input  logic [c_pos_w-1:0] sniper_x,
    input  logic [c_pos_w-1:0] sniper_y,
    input  logic [c_pos_w-1:0] duck_x,
    input  logic [c_pos_w-1:0] duck_y,
    output logic               hit
);

    localparam logic [11:0] c_off_x = 12'(c_aim_off_x);
    localparam logic [11:0] c_off_y = 12'(c_aim_off_y);
    localparam logic [11:0] c_w     = 12'(c_duck_w);
    localparam logic [11:0] c_h     = 12'(c_duck_h);

    logic [11:0] w_cx;
    logic [11:0] w_cy;
    logic [11:0] w_x_lo;
    logic [11:0] w_y_lo;
    logic [11:0] w_x_hi;
    logic [11:0] w_y_hi;

    // One extra bit keeps every sum below 4096, so no comparison can wrap
    assign w_cx   = {1'b0, sniper_x} + c_off_x;
    assign w_cy   = {1'b0, sniper_y} + c_off_y;
    assign w_x_lo = {1'b0, duck_x};
    assign w_y_lo = {1'b0, duck_y};
    assign w_x_hi = w_x_lo + c_w;
    assign w_y_hi = w_y_lo + c_h;

    assign hit = (w_cx > w_x_lo) && (w_cx < w_x_hi) &&
                 (w_cy > w_y_lo) && (w_cy < w_y_hi);

endmodule
`default_nettype wire

// File: rtl/duck_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : duck_game_ctrl
// Brief   : Per-frame game engine: duck flight, shots, hit/fall, win/lose.
//           Define DUCK_ESCAPE_EN to let the duck escape after ESCAPE_FRAMES.
// Revision: 1.0 - initial release
// ============================================================================
module duck_game_ctrl
    import duck_game_pkg::*;
#(
    parameter int X_MIN         = c_bound_x_min,
    parameter int X_MAX         = c_bound_x_max,
    parameter int Y_MIN         = c_bound_y_min,
    parameter int Y_MAX         = c_bound_y_max,
    parameter int START_X       = 300,
    parameter int START_Y       = 400,
    parameter int STEP_X        = 4,
    parameter int STEP_Y        = 3,
    parameter int FALL_STEP     = 6,
    parameter int ESCAPE_FRAMES = 600
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               shoot,
    input  logic               restart,
    input  logic [c_pos_w-1:0] sniper_x,
    input  logic [c_pos_w-1:0] sniper_y,
    output logic [c_pos_w-1:0] blkpos_x,
    output logic [c_pos_w-1:0] blkpos_y,
    output logic [1:0]         press_count,
    output logic               flag_shoot,
    output logic               flag
);

    localparam logic [11:0] c_x_min   = 12'(X_MIN);
    localparam logic [11:0] c_x_max   = 12'(X_MAX);
    localparam logic [11:0] c_y_min   = 12'(Y_MIN);
    localparam logic [11:0] c_y_max   = 12'(Y_MAX);
    localparam logic [11:0] c_step_x  = 12'(STEP_X);
    localparam logic [11:0] c_step_y  = 12'(STEP_Y);
    localparam logic [11:0] c_fall    = 12'(FALL_STEP);
    localparam logic [10:0] c_start_x = 11'(START_X);
    localparam logic [10:0] c_start_y = 11'(START_Y);

    state_t      r_state,      w_state_nxt;
    logic [10:0] r_x,          w_x_nxt;
    logic [10:0] r_y,          w_y_nxt;
    logic        r_dir_x,      w_dir_x_nxt;
    logic        r_dir_y,      w_dir_y_nxt;
    logic [1:0]  r_press,      w_press_nxt;
    logic        r_flag,       w_flag_nxt;
    logic        r_flag_shoot, w_flag_shoot_nxt;

    logic        w_hit;
    logic        w_escape;
    logic [11:0] w_x_ext;
    logic [11:0] w_y_ext;
    logic [11:0] w_fall_y;
    logic [10:0] w_fly_x;
    logic [10:0] w_fly_y;
    logic        w_fly_dir_x;
    logic        w_fly_dir_y;

    assign w_x_ext  = {1'b0, r_x};
    assign w_y_ext  = {1'b0, r_y};
    assign w_fall_y = w_y_ext + c_fall;

    duck_hit_detect u_hit_detect (
        .sniper_x (sniper_x),
        .sniper_y (sniper_y),
        .duck_x   (r_x),
        .duck_y   (r_y),
        .hit      (w_hit)
    );

`ifdef DUCK_ESCAPE_EN
    localparam int c_esc_w = (ESCAPE_FRAMES > 2) ? $clog2(ESCAPE_FRAMES) : 1;

    logic [c_esc_w-1:0] r_esc_cnt, w_esc_cnt_nxt;

    assign w_escape = frame_tick && (r_esc_cnt == c_esc_w'(ESCAPE_FRAMES - 1));
`else
    assign w_escape = 1'b0;
`endif

    // Dir bit 1 means increasing coordinate; a step past a bound clamps and reverses
    always_comb begin
        w_fly_x     = r_x;
        w_fly_y     = r_y;
        w_fly_dir_x = r_dir_x;
        w_fly_dir_y = r_dir_y;
        if (r_dir_x) begin
            if (w_x_ext + c_step_x > c_x_max) begin
                w_fly_x     = c_x_max[10:0];
                w_fly_dir_x = 1'b0;
            end else begin
                w_fly_x = 11'(w_x_ext + c_step_x);
            end
        end else begin
            if (w_x_ext < c_x_min + c_step_x) begin
                w_fly_x     = c_x_min[10:0];
                w_fly_dir_x = 1'b1;
            end else begin
                w_fly_x = 11'(w_x_ext - c_step_x);
            end
        end
        if (r_dir_y) begin
            if (w_y_ext + c_step_y > c_y_max) begin
                w_fly_y     = c_y_max[10:0];
                w_fly_dir_y = 1'b0;
            end else begin
                w_fly_y = 11'(w_y_ext + c_step_y);
            end
        end else begin
            if (w_y_ext < c_y_min + c_step_y) begin
                w_fly_y     = c_y_min[10:0];
                w_fly_dir_y = 1'b1;
            end else begin
                w_fly_y = 11'(w_y_ext - c_step_y);
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_dir_x_nxt      = r_dir_x;
        w_dir_y_nxt      = r_dir_y;
        w_press_nxt      = r_press;
        w_flag_nxt       = r_flag;
        w_flag_shoot_nxt = r_flag_shoot;
`ifdef DUCK_ESCAPE_EN
        w_esc_cnt_nxt    = r_esc_cnt;
`endif
        case (r_state)
            FLY: begin
                if (shoot && r_press != 2'd3) begin
                    w_press_nxt = r_press + 2'd1;
                end
                // The shot sees the pre-move position; a hit freezes the duck in place
                if (shoot && w_hit) begin
                    w_state_nxt = FALL;
                    w_flag_nxt  = 1'b1;
                end else begin
                    if (frame_tick) begin
                        w_x_nxt     = w_fly_x;
                        w_y_nxt     = w_fly_y;
                        w_dir_x_nxt = w_fly_dir_x;
                        w_dir_y_nxt = w_fly_dir_y;
`ifdef DUCK_ESCAPE_EN
                        w_esc_cnt_nxt = r_esc_cnt + 1'b1;
`endif
                    end
                    if ((shoot && r_press == 2'd2) || w_escape) begin
                        w_state_nxt      = DONE;
                        w_press_nxt      = 2'd3;
                        w_flag_nxt       = 1'b0;
                        w_flag_shoot_nxt = 1'b0;
                    end
                end
            end
            FALL: begin
                if (frame_tick) begin
                    if (w_fall_y >= c_y_max) begin
                        w_y_nxt          = c_y_max[10:0];
                        w_state_nxt      = DONE;
                        w_press_nxt      = 2'd3;
                        w_flag_shoot_nxt = 1'b0;
                    end else begin
                        w_y_nxt = w_fall_y[10:0];
                    end
                end
            end
            DONE: begin
                if (restart) begin
                    w_state_nxt      = FLY;
                    w_x_nxt          = c_start_x;
                    w_y_nxt          = c_start_y;
                    w_dir_x_nxt      = 1'b1;
                    w_dir_y_nxt      = 1'b0;
                    w_press_nxt      = 2'd0;
                    w_flag_nxt       = 1'b0;
                    w_flag_shoot_nxt = 1'b1;
`ifdef DUCK_ESCAPE_EN
                    w_esc_cnt_nxt    = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = FLY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FLY;
            r_x          <= c_start_x;
            r_y          <= c_start_y;
            r_dir_x      <= 1'b1;
            r_dir_y      <= 1'b0;
            r_press      <= 2'd0;
            r_flag       <= 1'b0;
            r_flag_shoot <= 1'b1;
`ifdef DUCK_ESCAPE_EN
            r_esc_cnt    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_dir_x      <= w_dir_x_nxt;
            r_dir_y      <= w_dir_y_nxt;
            r_press      <= w_press_nxt;
            r_flag       <= w_flag_nxt;
            r_flag_shoot <= w_flag_shoot_nxt;
`ifdef DUCK_ESCAPE_EN
            r_esc_cnt    <= w_esc_cnt_nxt;
`endif
        end
    end

    assign blkpos_x    = r_x;
    assign blkpos_y    = r_y;
    assign press_count = r_press;
    assign flag_shoot  = r_flag_shoot;
    assign flag        = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_duck_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_duck_game_ctrl
// Brief   : Directed and randomized checks of duck_game_ctrl against a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_duck_game_ctrl;

    localparam int c_x_min = 10;
    localparam int c_x_max = 1197;
    localparam int c_y_min = 10;
    localparam int c_y_max = 536;
    localparam int c_esc   = 600;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        shoot;
    logic        restart;
    logic [10:0] sniper_x;
    logic [10:0] sniper_y;
    logic [10:0] blkpos_x;
    logic [10:0] blkpos_y;
    logic [1:0]  press_count;
    logic        flag_shoot;
    logic        flag;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: phase 0 = flying, 1 = falling, 2 = round over
    int m_x, m_y, m_dx, m_dy, m_press, m_flag, m_phase, m_esc;

    duck_game_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .shoot       (shoot),
        .restart     (restart),
        .sniper_x    (sniper_x),
        .sniper_y    (sniper_y),
        .blkpos_x    (blkpos_x),
        .blkpos_y    (blkpos_y),
        .press_count (press_count),
        .flag_shoot  (flag_shoot),
        .flag        (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_x = 300; m_y = 400; m_dx = 1; m_dy = -1;
        m_press = 0; m_flag = 0; m_phase = 0; m_esc = 0;
    endtask

    task automatic model_end_round();
        m_phase = 2;
        m_press = 3;
    endtask

    task automatic model_step(input bit t, input bit s, input bit r, input int sx, input int sy);
        int  cx, cy;
        bit  hit;
        case (m_phase)
            0: begin
                cx  = sx + 15;
                cy  = sy + 13;
                hit = s && (cx > m_x) && (cx < m_x + 71) && (cy > m_y) && (cy < m_y + 54);
                if (s && m_press < 3) m_press++;
                if (hit) begin
                    m_phase = 1;
                    m_flag  = 1;
                end else begin
                    if (t) begin
                        m_x += 4 * m_dx;
                        if (m_x > c_x_max) begin m_x = c_x_max; m_dx = -m_dx; end
                        else if (m_x < c_x_min) begin m_x = c_x_min; m_dx = -m_dx; end
                        m_y += 3 * m_dy;
                        if (m_y > c_y_max) begin m_y = c_y_max; m_dy = -m_dy; end
                        else if (m_y < c_y_min) begin m_y = c_y_min; m_dy = -m_dy; end
                        m_esc++;
                    end
                    if (s && m_press == 3) model_end_round();
`ifdef DUCK_ESCAPE_EN
                    if (m_esc >= c_esc) model_end_round();
`endif
                end
            end
            1: begin
                if (t) begin
                    m_y += 6;
                    if (m_y >= c_y_max) begin
                        m_y = c_y_max;
                        model_end_round();
                    end
                end
            end
            default: begin
                if (r) model_reset();
            end
        endcase
    endtask

    task automatic compare_all();
        chk("blkpos_x",    32'(blkpos_x),    m_x);
        chk("blkpos_y",    32'(blkpos_y),    m_y);
        chk("press_count", 32'(press_count), m_press);
        chk("flag",        32'(flag),        m_flag);
        chk("flag_shoot",  32'(flag_shoot),  (m_phase != 2) ? 1 : 0);
    endtask

    task automatic cycle(input bit t, input bit s, input bit r, input int sx, input int sy);
        frame_tick = t;
        shoot      = s;
        restart    = r;
        sniper_x   = sx[10:0];
        sniper_y   = sy[10:0];
        @(posedge clk);
        model_step(t, s, r, sx, sy);
        #1;
        frame_tick = 1'b0;
        shoot      = 1'b0;
        restart    = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        int sx, sy;
        bit t, s, r;
        rst = 1'b1; frame_tick = 1'b0; shoot = 1'b0; restart = 1'b0;
        sniper_x = '0; sniper_y = '0;
        repeat (2) @(posedge clk);
        do_reset();
        chk("reset_x", 32'(blkpos_x), 300);
        chk("reset_y", 32'(blkpos_y), 400);

        repeat (10) cycle(1, 0, 0, 0, 0);
        chk("ten_ticks_x", 32'(blkpos_x), 340);
        chk("ten_ticks_y", 32'(blkpos_y), 370);
        chk("ten_ticks_press", 32'(press_count), 0);
        chk("ten_ticks_fs", 32'(flag_shoot), 1);

        // Fly right until x=1196, then the bounce at the right edge
        for (int i = 0; i < 400 && m_x != 1196; i++) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("bounce_clamp_x", 32'(blkpos_x), 1197);
        cycle(1, 0, 0, 0, 0);
        chk("bounce_back_x", 32'(blkpos_x), 1193);

        cycle(0, 1, 0, m_x + 20, m_y + 10);
        chk("hit_press", 32'(press_count), 1);
        chk("hit_flag", 32'(flag), 1);
        for (int i = 0; i < 200 && m_phase != 2; i++) cycle(1, 0, 0, 0, 0);
        chk("fall_y", 32'(blkpos_y), 536);
        chk("win_flag", 32'(flag), 1);
        chk("win_press", 32'(press_count), 3);
        chk("win_fs", 32'(flag_shoot), 0);
        cycle(0, 1, 0, 0, 0);

        cycle(0, 0, 1, 0, 0);
        chk("restart_x", 32'(blkpos_x), 300);
        chk("restart_y", 32'(blkpos_y), 400);
        chk("restart_flag", 32'(flag), 0);
        chk("restart_press", 32'(press_count), 0);

        cycle(0, 0, 1, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0);
        chk("miss2_fs", 32'(flag_shoot), 1);
        cycle(0, 1, 0, 0, 0);
        chk("miss3_flag", 32'(flag), 0);
        chk("miss3_press", 32'(press_count), 3);
        chk("miss3_fs", 32'(flag_shoot), 0);
        cycle(1, 1, 0, 0, 0);
        chk("miss4_x", 32'(blkpos_x), 300);

        cycle(0, 0, 1, 0, 0);
        cycle(1, 1, 0, 320, 410);
        chk("same_cycle_x", 32'(blkpos_x), 300);
        chk("same_cycle_y", 32'(blkpos_y), 400);
        chk("same_cycle_flag", 32'(flag), 1);
        cycle(0, 0, 1, 0, 0);
        chk("restart_in_fall_fs", 32'(flag_shoot), 1);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                sx = m_x - 20 + int'($urandom_range(0, 70));
                sy = m_y - 15 + int'($urandom_range(0, 55));
                if (sx < 0) sx = 0;
                if (sy < 0) sy = 0;
                if (sx > 2047) sx = 2047;
                if (sy > 2047) sy = 2047;
            end else begin
                sx = int'($urandom_range(0, 2047));
                sy = int'($urandom_range(0, 2047));
            end
            cycle(t, s, r, sx, sy);
        end

`ifdef DUCK_ESCAPE_EN
        do_reset();
        repeat (c_esc - 1) cycle(1, 0, 0, 0, 0);
        chk("escape_pre_fs", 32'(flag_shoot), 1);
        cycle(1, 0, 0, 0, 0);
        chk("escape_fs", 32'(flag_shoot), 0);
        chk("escape_flag", 32'(flag), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
